// File: rtl/reg_file.sv
// reg_file: multi-ported register file with DEPTH = 2**ADDR_W registers of WIDTH bits.
// It has one synchronous write port and two combinational read ports.
// Ports:
//   clk            - rising-edge clock for all register updates
//   rst_n          - asynchronous active-low clear of every register
//   we/waddr/wdata - write port; the write lands at the rising edge of clk
//   raddr1/rdata1  - read port 1, zero-cycle latency
//   raddr2/rdata2  - read port 2, zero-cycle latency
// Parameters:
//   ZERO_R0 - when 1, register 0 is hardwired to zero and writes to it are dropped
//   BYPASS  - when 1, a write in progress is forwarded to a matching read port
module reg_file #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ok_c;
  logic             zero_r0_c;
  logic             bypass_c;

  assign zero_r0_c = (ZERO_R0 != 0);
  assign bypass_c  = (BYPASS != 0);

  // A write to r0 is dropped when r0 is hardwired to zero.
  assign wr_ok_c = we && !(zero_r0_c && (waddr == '0));

  // Next-state: only the addressed register takes wdata; everything else holds.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok_c) begin
      mem_d[waddr] = wdata;
    end
  end

  // One flop bank per register, cleared asynchronously.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[g] <= '0;
      end else begin
        mem_q[g] <= mem_d[g];
      end
    end
  end

  // Read port 1: forced zero for r0, then forwarding, then stored value.
  always_comb begin
    rdata1 = mem_q[raddr1];
    if (zero_r0_c && (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (bypass_c && we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rdata2 = mem_q[raddr2];
    if (zero_r0_c && (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (bypass_c && we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end

endmodule
